// File: rtl/signal_analyzer.sv
// signal_analyzer: recovers a DDS phase increment from a received sample stream.
// It counts rising midpoint crossings, with hysteresis, over a window of
// 2**WIN_LOG2 valid samples. The count is then scaled into a 32-bit phase
// increment estimate.
// Optional min/max tracking is enabled by defining SIGNAL_ANALYZER_MINMAX_EN.
// Without it, sample_min and sample_max read as zero.
module signal_analyzer #(
    parameter int unsigned WIN_LOG2 = 12,
    parameter logic [31:0] MID      = 32'h8000_0000,
    parameter logic [31:0] HYST     = 32'h0100_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [31:0]         sample,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [WIN_LOG2-1:0] crossings,
    output logic [31:0]         est_adder,
    output logic [31:0]         sample_min,
    output logic [31:0]         sample_max
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [31:0] LO_TH = MID - HYST;
    localparam logic [31:0] HI_TH = MID + HYST;

    logic [1:0]          state;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2-1:0] cross_cnt;
    logic [WIN_LOG2-1:0] cross_cnt_nxt;
    logic                armed;
    logic                armed_nxt;
    logic                last_smp;
    logic                smp_take;

    // A sample is consumed only while measuring. An abort on the same cycle wins.
    assign smp_take = (state == S_MEASURE) && sample_valid && !abort;

    // The window counter wraps to zero on the final sample, so all-ones marks the last one.
    assign last_smp = &win_cnt;

    assign busy = (state == S_MEASURE);
    assign done = (state == S_DONE);

    // Hysteresis crossing detector: a low sample arms it, and a high sample while armed counts.
    always_comb begin
        cross_cnt_nxt = cross_cnt;
        armed_nxt     = armed;
        if (sample < LO_TH) begin
            armed_nxt = 1'b1;
        end else if ((sample >= HI_TH) && armed) begin
            cross_cnt_nxt = cross_cnt + WIN_LOG2'(1);
            armed_nxt     = 1'b0;
        end
    end

    // Control FSM and crossing statistics. Results are written from the next-state values,
    // so the final sample is counted on the same edge that raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            win_cnt   <= '0;
            cross_cnt <= '0;
            armed     <= 1'b0;
            crossings <= '0;
            est_adder <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state     <= S_MEASURE;
                        win_cnt   <= '0;
                        cross_cnt <= '0;
                        armed     <= 1'b0;
                    end
                end
                S_MEASURE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (sample_valid) begin
                        win_cnt   <= win_cnt + WIN_LOG2'(1);
                        cross_cnt <= cross_cnt_nxt;
                        armed     <= armed_nxt;
                        if (last_smp) begin
                            state     <= S_DONE;
                            crossings <= cross_cnt_nxt;
                            est_adder <= {cross_cnt_nxt, {(32 - WIN_LOG2){1'b0}}};
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SIGNAL_ANALYZER_MINMAX_EN
    logic [31:0] min_acc;
    logic [31:0] max_acc;
    logic [31:0] min_nxt;
    logic [31:0] max_nxt;

    // Running extremes, including the sample presented this cycle.
    always_comb begin
        min_nxt = (sample < min_acc) ? sample : min_acc;
        max_nxt = (sample > max_acc) ? sample : max_acc;
    end

    // Accumulators are datapath only. Each window reseeds them, so they need no reset.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && start && !abort) begin
            min_acc <= 32'hFFFF_FFFF;
            max_acc <= 32'h0000_0000;
        end else if (smp_take) begin
            min_acc <= min_nxt;
            max_acc <= max_nxt;
        end
    end

    // Published extremes are updated alongside crossings when the window completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_min <= '0;
            sample_max <= '0;
        end else if (smp_take && last_smp) begin
            sample_min <= min_nxt;
            sample_max <= max_nxt;
        end
    end
`else
    assign sample_min = 32'd0;
    assign sample_max = 32'd0;
`endif

endmodule

// File: tb/tb_signal_analyzer.sv
// Directed testbench for signal_analyzer (WIN_LOG2 = 12, default thresholds).
// Min/max expectations follow SIGNAL_ANALYZER_MINMAX_EN.
module tb_signal_analyzer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [31:0] sample;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [11:0] crossings;
    logic [31:0] est_adder;
    logic [31:0] sample_min;
    logic [31:0] sample_max;

    int total = 0;
    int bad   = 0;
    int cyc;

`ifdef SIGNAL_ANALYZER_MINMAX_EN
    localparam bit MM_EN = 1'b1;
`else
    localparam bit MM_EN = 1'b0;
`endif

    signal_analyzer #(.WIN_LOG2(12)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .crossings    (crossings),
        .est_adder    (est_adder),
        .sample_min   (sample_min),
        .sample_max   (sample_max)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mm(input logic [31:0] v);
        return MM_EN ? v : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waveform generators indexed by valid-sample number.
    function automatic logic [31:0] gen(input int kind, input int idx);
        logic [31:0] r;
        case (kind)
            0:       r = {idx[7:0], 24'h0};                          // saw, period 256
            1:       r = 32'h4000_0000;                              // constant
            2:       r = idx[0] ? 32'hFFFF_FFFF : 32'h0000_0000;     // full swing
            3:       r = idx[0] ? 32'h8100_0000 : 32'h7F00_0000;     // band edges, never arms
            default: r = idx[0] ? 32'h8100_0000 : 32'h7EFF_FFFF;     // just outside band
        endcase
        return r;
    endfunction

    // Drive n valid samples. With gaps, insert one invalid cycle (garbage data) between them.
    task automatic drive(input int kind, input int n, input bit gaps, output int cycles);
        int v = 0;
        int c = 0;
        bit ph = 1'b0;
        while (v < n) begin
            if (gaps && ph) begin
                sample_valid = 1'b0;
                sample       = c[1] ? 32'hFFFF_FFFF : 32'h0;
            end else begin
                sample_valid = 1'b1;
                sample       = gen(kind, v);
                v++;
            end
            if (gaps) ph = ~ph;
            @(posedge clk); #1;
            c++;
        end
        sample_valid = 1'b0;
        cycles = c;
    endtask

    task automatic start_win();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sample_valid = 1'b0; sample = 32'h0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cross", 32'(crossings), 32'd0);
        check("rst_est", est_adder, 32'd0);
        check("rst_min", sample_min, 32'd0);
        check("rst_max", sample_max, 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Saw, continuous valid
        start_win();
        check("saw_busy", 32'(busy), 32'd1);
        drive(0, 4096, 1'b0, cyc);
        check("saw_done", 32'(done), 32'd1);
        check("saw_busy_done", 32'(busy), 32'd0);
        check("saw_cyc", 32'(cyc), 32'd4096);
        check("saw_cross", 32'(crossings), 32'd16);
        check("saw_est", est_adder, 32'h0100_0000);
        check("saw_min", sample_min, mm(32'h0));
        check("saw_max", sample_max, mm(32'hFF00_0000));
        step();
        check("saw_done_pulse", 32'(done), 32'd0);
        check("saw_idle", 32'(busy), 32'd0);
        check("saw_hold", 32'(crossings), 32'd16);

        // Constant
        start_win();
        drive(1, 4096, 1'b0, cyc);
        check("const_done", 32'(done), 32'd1);
        check("const_cross", 32'(crossings), 32'd0);
        check("const_est", est_adder, 32'd0);
        check("const_min", sample_min, mm(32'h4000_0000));
        check("const_max", sample_max, mm(32'h4000_0000));
        step();

        // Full-swing alternation starting low
        start_win();
        drive(2, 4096, 1'b0, cyc);
        check("alt_done", 32'(done), 32'd1);
        check("alt_cross", 32'(crossings), 32'd2048);
        check("alt_est", est_adder, 32'h8000_0000);
        check("alt_min", sample_min, mm(32'h0));
        check("alt_max", sample_max, mm(32'hFFFF_FFFF));
        step();

        // Band edges: 0x7F00_0000 is not below the low threshold
        start_win();
        drive(3, 4096, 1'b0, cyc);
        check("band_done", 32'(done), 32'd1);
        check("band_cross", 32'(crossings), 32'd0);
        check("band_est", est_adder, 32'd0);
        check("band_max", sample_max, mm(32'h8100_0000));
        step();

        // One LSB below the band arms; exactly MID+HYST counts
        start_win();
        drive(4, 4096, 1'b0, cyc);
        check("edge_done", 32'(done), 32'd1);
        check("edge_cross", 32'(crossings), 32'd2048);
        check("edge_min", sample_min, mm(32'h7EFF_FFFF));
        step();

        // Saw with valid every other cycle
        start_win();
        drive(0, 4096, 1'b1, cyc);
        check("gap_done", 32'(done), 32'd1);
        check("gap_cyc", 32'(cyc), 32'd8191);
        check("gap_cross", 32'(crossings), 32'd16);
        check("gap_est", est_adder, 32'h0100_0000);
        check("gap_max", sample_max, mm(32'hFF00_0000));
        step();

        // Abort at sample 1000
        start_win();
        drive(2, 1000, 1'b0, cyc);
        abort = 1'b1; sample_valid = 1'b1; sample = 32'h0;
        step();
        abort = 1'b0; sample_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cross", 32'(crossings), 32'd16);
        check("abort_est", est_adder, 32'h0100_0000);
        step();
        check("abort_nodone", 32'(done), 32'd0);
        start_win();
        drive(2, 4096, 1'b0, cyc);
        check("reab_done", 32'(done), 32'd1);
        check("reab_cross", 32'(crossings), 32'd2048);
        step();

        // Abort coinciding with the final sample
        start_win();
        drive(1, 4095, 1'b0, cyc);
        abort = 1'b1; sample_valid = 1'b1; sample = 32'h4000_0000;
        step();
        abort = 1'b0; sample_valid = 1'b0;
        check("abfin_done", 32'(done), 32'd0);
        check("abfin_busy", 32'(busy), 32'd0);
        check("abfin_cross", 32'(crossings), 32'd2048);
        check("abfin_min", sample_min, mm(32'h0));

        // Start held high through MEASURE and DONE
        start = 1'b1;
        step();
        check("hold_busy", 32'(busy), 32'd1);
        drive(0, 4096, 1'b0, cyc);
        check("hold_done", 32'(done), 32'd1);
        check("hold_cyc", 32'(cyc), 32'd4096);
        check("hold_cross", 32'(crossings), 32'd16);
        step();
        check("hold_idle_busy", 32'(busy), 32'd0);
        check("hold_idle_done", 32'(done), 32'd0);
        step();
        check("hold_rearm", 32'(busy), 32'd1);
        start = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        check("hold_abort", 32'(busy), 32'd0);

        // Reset mid-window
        start_win();
        drive(2, 500, 1'b0, cyc);
        check("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_cross", 32'(crossings), 32'd0);
        check("mid_est", est_adder, 32'd0);
        check("mid_min", sample_min, 32'd0);
        check("mid_max", sample_max, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
